// File: rtl/alu_arbiter_if.sv
// Request/response channels between two ALU requesters and alu_arbiter.
// Signal names keep their legacy _i/_o suffixes as seen from the arbiter.
interface alu_arbiter_if #(
    parameter int DATA_W = 32
) ();
    logic              req0_valid_i;
    logic [DATA_W-1:0] req0_src1_i;
    logic [DATA_W-1:0] req0_src2_i;
    logic [3:0]        req0_ctrl_i;
    logic              req0_ready_o;
    logic              rsp0_valid_o;
    logic [DATA_W-1:0] rsp0_result_o;
    logic              rsp0_zero_o;
    logic              rsp0_ready_i;

    logic              req1_valid_i;
    logic [DATA_W-1:0] req1_src1_i;
    logic [DATA_W-1:0] req1_src2_i;
    logic [3:0]        req1_ctrl_i;
    logic              req1_ready_o;
    logic              rsp1_valid_o;
    logic [DATA_W-1:0] rsp1_result_o;
    logic              rsp1_zero_o;
    logic              rsp1_ready_i;

    modport slave (
        input  req0_valid_i, req0_src1_i, req0_src2_i, req0_ctrl_i, rsp0_ready_i,
        input  req1_valid_i, req1_src1_i, req1_src2_i, req1_ctrl_i, rsp1_ready_i,
        output req0_ready_o, rsp0_valid_o, rsp0_result_o, rsp0_zero_o,
        output req1_ready_o, rsp1_valid_o, rsp1_result_o, rsp1_zero_o
    );

    modport master (
        output req0_valid_i, req0_src1_i, req0_src2_i, req0_ctrl_i, rsp0_ready_i,
        output req1_valid_i, req1_src1_i, req1_src2_i, req1_ctrl_i, rsp1_ready_i,
        input  req0_ready_o, rsp0_valid_o, rsp0_result_o, rsp0_zero_o,
        input  req1_ready_o, rsp1_valid_o, rsp1_result_o, rsp1_zero_o
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters,
// with a one-entry registered response buffer per requester.
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    alu_arbiter_if.slave      bus,
    output logic [DATA_W-1:0] alu_src1_o,
    output logic [DATA_W-1:0] alu_src2_o,
    output logic [3:0]        alu_ctrl_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_zero_i,
    output logic [CNT_W-1:0]  ops_cnt_o
);
    logic              elig0, elig1;
    logic              grant0, grant1;
    logic              fire0, fire1;
    logic              last_grant;
    logic              rsp0_valid, rsp1_valid;
    logic [DATA_W-1:0] rsp0_result, rsp1_result;
    logic              rsp0_zero, rsp1_zero;
    logic [CNT_W-1:0]  ops_cnt;

    // A full buffer that is draining this cycle can still take a new issue.
    assign elig0 = bus.req0_valid_i & (~rsp0_valid | bus.rsp0_ready_i);
    assign elig1 = bus.req1_valid_i & (~rsp1_valid | bus.rsp1_ready_i);

    // last_grant = 1 means requester 1 fired last, so requester 0 wins a tie.
    assign grant0 = elig0 & (~elig1 | last_grant);
    assign grant1 = elig1 & (~elig0 | ~last_grant);

    assign fire0 = bus.req0_valid_i & grant0;
    assign fire1 = bus.req1_valid_i & grant1;

    assign bus.req0_ready_o  = grant0;
    assign bus.req1_ready_o  = grant1;
    assign bus.rsp0_valid_o  = rsp0_valid;
    assign bus.rsp0_result_o = rsp0_result;
    assign bus.rsp0_zero_o   = rsp0_zero;
    assign bus.rsp1_valid_o  = rsp1_valid;
    assign bus.rsp1_result_o = rsp1_result;
    assign bus.rsp1_zero_o   = rsp1_zero;
    assign ops_cnt_o         = ops_cnt;

    always_comb begin
        alu_src1_o = '0;
        alu_src2_o = '0;
        alu_ctrl_o = '0;
        if (grant0) begin
            alu_src1_o = bus.req0_src1_i;
            alu_src2_o = bus.req0_src2_i;
            alu_ctrl_o = bus.req0_ctrl_i;
        end else if (grant1) begin
            alu_src1_o = bus.req1_src1_i;
            alu_src2_o = bus.req1_src2_i;
            alu_ctrl_o = bus.req1_ctrl_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rsp0_valid  <= 1'b0;
            rsp0_result <= '0;
            rsp0_zero   <= 1'b0;
        end else if (fire0) begin
            rsp0_valid  <= 1'b1;
            rsp0_result <= alu_result_i;
            rsp0_zero   <= alu_zero_i;
        end else if (bus.rsp0_ready_i) begin
            rsp0_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rsp1_valid  <= 1'b0;
            rsp1_result <= '0;
            rsp1_zero   <= 1'b0;
        end else if (fire1) begin
            rsp1_valid  <= 1'b1;
            rsp1_result <= alu_result_i;
            rsp1_zero   <= alu_zero_i;
        end else if (bus.rsp1_ready_i) begin
            rsp1_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_grant <= 1'b1;
            ops_cnt    <= '0;
        end else begin
            if (fire0) begin
                last_grant <= 1'b0;
            end else if (fire1) begin
                last_grant <= 1'b1;
            end
            if (fire0 | fire1) begin
                ops_cnt <= ops_cnt + CNT_W'(1);
            end
        end
    end
endmodule
